// File: rtl/piso_tx_pkg.sv
// Shared types and constants for the two-requester PISO transmit scheduler.
//   state_e      : scheduler FSM states
//   REQ0 / REQ1  : requester index encodings (also the grant_id values)
//   MAX_GAP      : largest supported inter-frame idle gap
//   GAP_CNT_W    : width of the gap counter
package piso_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   localparam logic        REQ0      = 1'b0;
   localparam logic        REQ1      = 1'b1;
   localparam int unsigned MAX_GAP   = 15;
   localparam int unsigned GAP_CNT_W = 4;

   // One-hot ready vector for a requester index.
   function automatic logic [1:0] req_onehot(input logic idx);
      return (idx == REQ1) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/piso_shift_core.sv
// WIDTH-bit parallel-load, shift-right register; bit 0 is the serial output.
//   clk, reset_n : clock, synchronous active-low reset
//   load         : capture load_data (wins over shift)
//   shift        : shift right by one with zero fill
//   load_data    : parallel word to capture
//   serial       : current LSB
module piso_shift_core #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] load_data,
   output logic             serial
);

   logic [WIDTH-1:0] sh_d;
   logic [WIDTH-1:0] sh_q;

   // Next register value: load, shift or hold.
   always_comb begin
      sh_d = sh_q;
      if (load) begin
         sh_d = load_data;
      end else if (shift) begin
         sh_d = {1'b0, sh_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sh_q <= '0;
      end else begin
         sh_q <= sh_d;
      end
   end

   assign serial = sh_q[0];

endmodule

// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler sharing one PISO shift datapath between two requesters.
//   clk, reset_n         : clock, synchronous active-low reset
//   req_valid[1:0]       : requester i has a word
//   req_data0/req_data1  : requester words
//   req_ready[1:0]       : word i accepted this cycle (combinational, one-hot or zero)
//   serial_out           : serial bit, LSB first
//   serial_valid         : serial_out carries frame data
//   frame_start/done     : first / last bit of a frame
//   grant_id             : requester owning the frame in flight
//   busy                 : scheduler not idle
module piso_tx_scheduler
   import piso_tx_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned GAP   = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       req_valid,
   input  logic [WIDTH-1:0] req_data0,
   input  logic [WIDTH-1:0] req_data1,
   output logic [1:0]       req_ready,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             frame_start,
   output logic             frame_done,
   output logic             grant_id,
   output logic             busy
);

   localparam int unsigned CNT_W   = $clog2(WIDTH);
   localparam int unsigned GAP_EFF = (GAP > MAX_GAP) ? MAX_GAP : GAP;
   localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
      GAP_CNT_W'((GAP_EFF == 0) ? 0 : GAP_EFF - 1);
   localparam logic GAP_EN = (GAP_EFF != 0);

   state_e                 state_d, state_q;
   logic [CNT_W-1:0]       bit_cnt_d, bit_cnt_q;
   logic [GAP_CNT_W-1:0]   gap_cnt_d, gap_cnt_q;
   logic                   rr_ptr_d, rr_ptr_q;
   logic                   grant_d, grant_q;
   logic                   serial_valid_d, serial_valid_q;
   logic                   frame_start_d, frame_start_q;
   logic                   frame_done_d, frame_done_q;
   logic                   busy_d, busy_q;

   logic                   accept_win;
   logic                   winner;
   logic                   xfer;
   logic                   load;
   logic                   shift;
   logic [WIDTH-1:0]       load_data;

   // Arbiter: a back-to-back reload is only possible on the last bit when no gap is configured.
   always_comb begin
      accept_win = (state_q == ST_IDLE) ||
                   ((state_q == ST_SHIFT) && (bit_cnt_q == LAST_BIT) && !GAP_EN);
      winner     = req_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
      req_ready  = 2'b00;
      if (reset_n && accept_win && (req_valid != 2'b00)) begin
         req_ready = req_onehot(winner);
      end
      xfer       = (req_ready != 2'b00);
   end

   // Next-state, counters and next values of the registered outputs.
   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      gap_cnt_d      = gap_cnt_q;
      rr_ptr_d       = rr_ptr_q;
      grant_d        = grant_q;
      load           = 1'b0;
      shift          = 1'b0;
      load_data      = (winner == REQ1) ? req_data1 : req_data0;
      serial_valid_d = 1'b0;
      frame_start_d  = 1'b0;
      frame_done_d   = 1'b0;
      busy_d         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            shift     = 1'b1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
               bit_cnt_d = '0;
               if (xfer) begin
                  state_d = ST_SHIFT;
               end else if (GAP_EN) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = GAP_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (xfer) begin
         load      = 1'b1;
         bit_cnt_d = '0;
         grant_d   = winner;
         rr_ptr_d  = ~winner;
      end

      // Flags registered from the next state so they align with the shifted-out bit.
      serial_valid_d = (state_d == ST_SHIFT);
      frame_start_d  = (state_d == ST_SHIFT) && (bit_cnt_d == '0);
      frame_done_d   = (state_d == ST_SHIFT) && (bit_cnt_d == LAST_BIT);
      busy_d         = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         bit_cnt_q      <= '0;
         gap_cnt_q      <= '0;
         rr_ptr_q       <= REQ0;
         grant_q        <= REQ0;
         serial_valid_q <= 1'b0;
         frame_start_q  <= 1'b0;
         frame_done_q   <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         gap_cnt_q      <= gap_cnt_d;
         rr_ptr_q       <= rr_ptr_d;
         grant_q        <= grant_d;
         serial_valid_q <= serial_valid_d;
         frame_start_q  <= frame_start_d;
         frame_done_q   <= frame_done_d;
         busy_q         <= busy_d;
      end
   end

   piso_shift_core #(
      .WIDTH (WIDTH)
   ) u_shift_core (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (load),
      .shift     (shift),
      .load_data (load_data),
      .serial    (serial_out)
   );

   assign serial_valid = serial_valid_q;
   assign frame_start  = frame_start_q;
   assign frame_done   = frame_done_q;
   assign grant_id     = grant_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Bench for piso_tx_scheduler: two instances (GAP=0 and GAP=3) share the stimulus;
// a per-cycle schedule of expected outputs is built from accepted words.
module tb_piso_tx_scheduler;

   localparam int W = 4;
   localparam int N = 2048;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset_n;
   logic [1:0]   valid [2];
   logic [W-1:0] d0    [2];
   logic [W-1:0] d1    [2];
   logic [1:0]   rdy   [2];
   logic         so    [2];
   logic         sv    [2];
   logic         fs    [2];
   logic         fd    [2];
   logic         gid   [2];
   logic         bsy   [2];

   piso_tx_scheduler #(.WIDTH(W), .GAP(0)) u_dut_g0 (
      .clk(clk), .reset_n(reset_n), .req_valid(valid[0]),
      .req_data0(d0[0]), .req_data1(d1[0]), .req_ready(rdy[0]),
      .serial_out(so[0]), .serial_valid(sv[0]), .frame_start(fs[0]),
      .frame_done(fd[0]), .grant_id(gid[0]), .busy(bsy[0])
   );

   piso_tx_scheduler #(.WIDTH(W), .GAP(3)) u_dut_g3 (
      .clk(clk), .reset_n(reset_n), .req_valid(valid[1]),
      .req_data0(d0[1]), .req_data1(d1[1]), .req_ready(rdy[1]),
      .serial_out(so[1]), .serial_valid(sv[1]), .frame_start(fs[1]),
      .frame_done(fd[1]), .grant_id(gid[1]), .busy(bsy[1])
   );

   // Expected outputs indexed by cycle number.
   bit e_sv   [2][N];
   bit e_bit  [2][N];
   bit e_fs   [2][N];
   bit e_fd   [2][N];
   bit e_busy [2][N];
   bit e_gid  [2][N];
   bit e_chkg [2][N];
   int free_at [2];
   bit rr      [2];
   int cyc;
   int n_checks;
   int n_pass;

   function automatic int gap_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // Compare this cycle's outputs, then advance the schedule for the coming edge.
   task automatic model_cycle(input int d);
      logic [1:0]   exp_rdy;
      bit           win;
      logic [W-1:0] w;
      int           g;
      string        p;
      g = gap_of(d);
      p = $sformatf("g%0d.", g);
      win = 1'b0;
      check({p, "serial_valid"}, 32'(sv[d]),  32'(e_sv[d][cyc]));
      check({p, "serial_out"},   32'(so[d]),  32'(e_bit[d][cyc]));
      check({p, "frame_start"},  32'(fs[d]),  32'(e_fs[d][cyc]));
      check({p, "frame_done"},   32'(fd[d]),  32'(e_fd[d][cyc]));
      check({p, "busy"},         32'(bsy[d]), 32'(e_busy[d][cyc]));
      if (e_chkg[d][cyc]) begin
         check({p, "grant_id"}, 32'(gid[d]), 32'(e_gid[d][cyc]));
      end

      exp_rdy = 2'b00;
      if (reset_n && (cyc >= free_at[d]) && (valid[d] != 2'b00)) begin
         win     = valid[d][rr[d]] ? rr[d] : !rr[d];
         exp_rdy = win ? 2'b10 : 2'b01;
      end
      check({p, "req_ready"}, 32'(rdy[d]), 32'(exp_rdy));

      if (!reset_n) begin
         for (int k = cyc + 1; k < N && k <= cyc + W + g + 2; k++) begin
            e_sv[d][k] = 0; e_bit[d][k] = 0; e_fs[d][k] = 0; e_fd[d][k] = 0;
            e_busy[d][k] = 0; e_gid[d][k] = 0; e_chkg[d][k] = 0;
         end
         e_chkg[d][cyc + 1] = 1;
         free_at[d] = cyc + 1;
         rr[d] = 0;
      end else if (exp_rdy != 2'b00) begin
         w = win ? d1[d] : d0[d];
         for (int k = 0; k < W; k++) begin
            e_sv[d][cyc + 1 + k]   = 1;
            e_bit[d][cyc + 1 + k]  = w[k];
            e_fs[d][cyc + 1 + k]   = (k == 0);
            e_fd[d][cyc + 1 + k]   = (k == W - 1);
            e_gid[d][cyc + 1 + k]  = win;
            e_chkg[d][cyc + 1 + k] = 1;
         end
         for (int k = 1; k <= W + g; k++) begin
            e_busy[d][cyc + k] = 1;
         end
         free_at[d] = cyc + W + g + ((g > 0) ? 1 : 0);
         rr[d] = !win;
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_cycle(0);
      model_cycle(1);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_req(input logic [1:0] v, input logic [W-1:0] a, input logic [W-1:0] b);
      for (int d = 0; d < 2; d++) begin
         valid[d] = v;
         d0[d]    = a;
         d1[d]    = b;
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      cyc      = 0;
      free_at[0] = 0; free_at[1] = 0;
      rr[0] = 0; rr[1] = 0;
      reset_n = 1'b0;
      set_req(2'b00, '0, '0);
      @(posedge clk);
      #1;

      // Reset held, then idle.
      step(); step();
      reset_n = 1'b1;
      repeat (3) step();

      // Single word from requester 0.
      set_req(2'b01, 4'b1011, 4'b0000);
      step();
      set_req(2'b00, '0, '0);
      repeat (8) step();

      // Contention: strict alternation.
      set_req(2'b11, 4'b1100, 4'b0011);
      repeat (24) step();
      set_req(2'b00, '0, '0);
      repeat (10) step();

      // Lone requester 1 held: gap enforcement on the GAP=3 instance.
      set_req(2'b10, 4'b0000, 4'b0101);
      repeat (24) step();
      set_req(2'b00, '0, '0);
      repeat (8) step();

      // Reset during bit 2 of a frame, then a fresh word.
      set_req(2'b01, 4'b1011, 4'b0000);
      step();
      set_req(2'b00, '0, '0);
      step(); step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      set_req(2'b01, 4'b0110, 4'b0000);
      step();
      set_req(2'b00, '0, '0);
      repeat (8) step();

      // Requester 1 pulses valid mid-frame, outside the accept window.
      set_req(2'b01, 4'b1001, 4'b0000);
      step();
      set_req(2'b00, '0, '0);
      step();
      set_req(2'b10, 4'b0000, 4'b1111);
      step();
      set_req(2'b00, '0, '0);
      repeat (8) step();

      // Randomized traffic with occasional resets.
      repeat (600) begin
         reset_n = ($urandom_range(0, 79) != 0);
         set_req(2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
         step();
      end
      reset_n = 1'b1;
      set_req(2'b00, '0, '0);
      repeat (10) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
